// File: rtl/data_memory_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the data memory arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface data_memory_arbiter_if;
    // Requester 0 (processor core)
    logic        r0_req_i;
    logic        r0_we_i;
    logic [31:0] r0_addr_i;
    logic [31:0] r0_wdata_i;
    logic        r0_gnt_o;
    logic        r0_rvalid_o;
    logic [31:0] r0_rdata_o;
    logic        r0_err_o;

    // Requester 1 (DMA / debug)
    logic        r1_req_i;
    logic        r1_we_i;
    logic [31:0] r1_addr_i;
    logic [31:0] r1_wdata_i;
    logic        r1_gnt_o;
    logic        r1_rvalid_o;
    logic [31:0] r1_rdata_o;
    logic        r1_err_o;

    // Single-port data memory
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    modport slave (
        input  r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
        output r0_gnt_o, r0_rvalid_o, r0_rdata_o, r0_err_o,
        input  r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
        output r1_gnt_o, r1_rvalid_o, r1_rdata_o, r1_err_o,
        output mem_we_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i
    );

    modport master (
        output r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
        input  r0_gnt_o, r0_rvalid_o, r0_rdata_o, r0_err_o,
        output r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
        input  r1_gnt_o, r1_rvalid_o, r1_rdata_o, r1_err_o,
        input  mem_we_o, mem_addr_o, mem_wd_o,
        output mem_rd_i
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port word-addressed data memory
// between the core (requester 0) and a secondary master (requester 1).
// Grant is combinational; the response (rvalid/rdata/err) is registered at
// the grant edge and visible one cycle later.
//
// state      | meaning
// -----------+------------------------------------------------------
// S_LAST_R0  | requester 0 had the most recent grant; r1 wins contention
// S_LAST_R1  | requester 1 had the most recent grant; r0 wins contention
module data_memory_arbiter #(
    parameter int MEM_WORDS = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    data_memory_arbiter_if.slave bus
);

    typedef enum logic {
        S_LAST_R0 = 1'b0,
        S_LAST_R1 = 1'b1
    } state_t;

    localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_legal0;
    logic        w_legal1;
    logic        w_sel_we;
    logic        w_sel_legal;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wd;
    logic [31:0] w_rsp_rdata;

    logic        r_rvalid0;
    logic [31:0] r_rdata0;
    logic        r_err0;
    logic        r_rvalid1;
    logic [31:0] r_rdata1;
    logic        r_err1;

    // Legal access: word aligned and inside the attached memory.
    assign w_legal0 = (bus.r0_addr_i[1:0] == 2'b00) && (bus.r0_addr_i[31:2] < LP_WORDS);
    assign w_legal1 = (bus.r1_addr_i[1:0] == 2'b00) && (bus.r1_addr_i[31:2] < LP_WORDS);

    // Arbitration state register; reset favours requester 0 at first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_LAST_R1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: remember whoever is granted, hold when idle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_gnt0) begin
            w_state_nxt = S_LAST_R0;
        end else if (w_gnt1) begin
            w_state_nxt = S_LAST_R1;
        end
    end

    // Outputs: grant decision and memory-side mux of the winner's request.
    always_comb begin
        w_gnt0      = bus.r0_req_i && (!bus.r1_req_i || (r_state == S_LAST_R1));
        w_gnt1      = bus.r1_req_i && (!bus.r0_req_i || (r_state == S_LAST_R0));
        w_sel_we    = 1'b0;
        w_sel_legal = 1'b0;
        w_sel_addr  = 32'h0;
        w_sel_wd    = 32'h0;
        if (w_gnt0) begin
            w_sel_we    = bus.r0_we_i;
            w_sel_legal = w_legal0;
            w_sel_addr  = bus.r0_addr_i;
            w_sel_wd    = bus.r0_wdata_i;
        end else if (w_gnt1) begin
            w_sel_we    = bus.r1_we_i;
            w_sel_legal = w_legal1;
            w_sel_addr  = bus.r1_addr_i;
            w_sel_wd    = bus.r1_wdata_i;
        end
    end

    // Illegal accesses never reach memory; reset also suppresses the write.
    assign bus.mem_we_o   = w_sel_we && w_sel_legal && !rst_i;
    assign bus.mem_addr_o = w_sel_addr;
    assign bus.mem_wd_o   = w_sel_wd;

    // Read data is only returned for legal reads; writes and errors return 0.
    assign w_rsp_rdata = (w_sel_we || !w_sel_legal) ? 32'h0 : bus.mem_rd_i;

    // Per-port response registers: one-cycle rvalid, data/err hold between grants.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid0 <= 1'b0;
            r_rdata0  <= 32'h0;
            r_err0    <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata1  <= 32'h0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            if (w_gnt0) begin
                r_rdata0 <= w_rsp_rdata;
                r_err0   <= !w_sel_legal;
            end
            if (w_gnt1) begin
                r_rdata1 <= w_rsp_rdata;
                r_err1   <= !w_sel_legal;
            end
        end
    end

    assign bus.r0_gnt_o    = w_gnt0;
    assign bus.r0_rvalid_o = r_rvalid0;
    assign bus.r0_rdata_o  = r_rdata0;
    assign bus.r0_err_o    = r_err0;
    assign bus.r1_gnt_o    = w_gnt1;
    assign bus.r1_rvalid_o = r_rvalid1;
    assign bus.r1_rdata_o  = r_rdata1;
    assign bus.r1_err_o    = r_err1;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a scoreboard per port: the
// stimulus pushes expected responses, an independent monitor pops them on rvalid.
module tb_data_memory_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [31:0] mem [64];

    data_memory_arbiter_if bus ();

    data_memory_arbiter #(.MEM_WORDS(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: asynchronous read, write at the rising edge; word i holds i+1 after preload.
    assign bus.mem_rd_i = (bus.mem_addr_o[31:8] == 24'h0) ? mem[bus.mem_addr_o[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i + 1);
        end else if (bus.mem_we_o) begin
            mem[bus.mem_addr_o[7:2]] <= bus.mem_wd_o;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.r0_rvalid_o === 1'b1) begin
            if (q0.size() == 0) begin
                check("r0 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("r0 rdata", bus.r0_rdata_o, e[31:0]);
                check("r0 err", 32'(bus.r0_err_o), 32'(e[32]));
            end
        end
        if (bus.r1_rvalid_o === 1'b1) begin
            if (q1.size() == 0) begin
                check("r1 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("r1 rdata", bus.r1_rdata_o, e[31:0]);
                check("r1 err", 32'(bus.r1_err_o), 32'(e[32]));
            end
        end
    end

    // One cycle: drive both requesters, check grant/memory side, queue expected responses.
    task automatic step(input string nm, input logic rst_v,
                        input logic q0v, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic q1v, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic eg0, input logic eg1, input logic ewe, input logic [31:0] eaddr,
                        input logic [31:0] er0, input logic ee0,
                        input logic [31:0] er1, input logic ee1);
        rst            = rst_v;
        bus.r0_req_i   = q0v;
        bus.r0_we_i    = w0;
        bus.r0_addr_i  = a0;
        bus.r0_wdata_i = d0;
        bus.r1_req_i   = q1v;
        bus.r1_we_i    = w1;
        bus.r1_addr_i  = a1;
        bus.r1_wdata_i = d1;
        @(negedge clk);
        check({nm, " gnt0"}, 32'(bus.r0_gnt_o), 32'(eg0));
        check({nm, " gnt1"}, 32'(bus.r1_gnt_o), 32'(eg1));
        check({nm, " mem_we"}, 32'(bus.mem_we_o), 32'(ewe));
        check({nm, " mem_addr"}, bus.mem_addr_o, eaddr);
        if (eg0 && !rst_v) q0.push_back({ee0, er0});
        if (eg1 && !rst_v) q1.push_back({ee1, er1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.r0_req_i = 0; bus.r0_we_i = 0; bus.r0_addr_i = 0; bus.r0_wdata_i = 0;
        bus.r1_req_i = 0; bus.r1_we_i = 0; bus.r1_addr_i = 0; bus.r1_wdata_i = 0;
        @(posedge clk); #1;
        preload = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst r0_rvalid", 32'(bus.r0_rvalid_o), 32'd0);
        check("rst r1_rvalid", 32'(bus.r1_rvalid_o), 32'd0);
        check("rst r0_rdata", bus.r0_rdata_o, 32'h0);
        check("rst r1_err", 32'(bus.r1_err_o), 32'd0);
        check("rst mem_we", 32'(bus.mem_we_o), 32'd0);
        check("rst mem_addr", bus.mem_addr_o, 32'h0);
        check("rst mem_wd", bus.mem_wd_o, 32'h0);
        @(posedge clk); #1;

        // Write then read-back on r0
        step("wr10", 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 1, 32'h10, 32'h0, 0, 0, 0);
        step("rd10", 0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        idle("idle1");
        check("mem word4", mem[4], 32'hDEADBEEF);

        // Fresh reset, then continuous contention alternates r0, r1, ...
        step("rstA", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            logic g0;
            g0 = (i % 2 == 0);
            step("cont", 0, 1, 0, 32'h14, 0, 1, 0, 32'h18, 0,
                 g0, !g0, 0, g0 ? 32'h14 : 32'h18, 32'd6, 0, 32'd7, 0);
        end

        // Lone r1 back-to-back reads of words 0..3
        for (int i = 0; i < 4; i++) begin
            step("r1burst", 0, 0, 0, 0, 0, 1, 0, 32'(4 * i), 0,
                 0, 1, 0, 32'(4 * i), 0, 0, 32'(i + 1), 0);
        end

        // Misaligned and out-of-range writes: granted, no write, err response
        step("wr102", 0, 1, 1, 32'h102, 32'hBAD0BAD0, 0, 0, 0, 0, 1, 0, 0, 32'h102, 32'h0, 1, 0, 0);
        step("wr100", 0, 1, 1, 32'h100, 32'hBAD0BAD0, 0, 0, 0, 0, 1, 0, 0, 32'h100, 32'h0, 1, 0, 0);
        idle("idle2");
        check("mem word0 kept", mem[0], 32'h1);

        // Reset during a grant cycle drops the response; r0 wins first contention after
        step("rstgnt", 1, 1, 0, 32'h14, 0, 1, 0, 32'h18, 0, 0, 1, 0, 32'h18, 0, 0, 0, 0);
        idle("idle3");
        step("post0", 0, 1, 0, 32'h14, 0, 1, 0, 32'h18, 0, 1, 0, 0, 32'h14, 32'd6, 0, 0, 0);
        step("post1", 0, 0, 0, 0, 0, 1, 0, 32'h18, 0, 0, 1, 0, 32'h18, 0, 0, 32'd7, 0);

        // Make last_grant=0, then same-word conflict: r1 write wins, r0 reads new data
        step("lone0", 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'd1, 0, 0, 0);
        step("conf1", 0, 1, 0, 32'h20, 0, 1, 1, 32'h20, 32'h55, 0, 1, 1, 32'h20, 0, 0, 32'h0, 0);
        step("conf0", 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, 32'h20, 32'h55, 0, 0, 0);
        idle("idle4");
        idle("idle5");

        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester arbiter that shares the single-port word-addressed data memory between the processor core (requester 0) and a secondary master such as a DMA or debug port (requester 1). It grants at most one access per cycle using round-robin priority, and drives the memory's write-enable, address and write-data inputs. It returns registered read data and a completion pulse to the granted requester one cycle later. It sits between the requesters and the data memory instance, replacing the direct core-to-memory connection.

## Interface

- MEM_WORDS, 64: number of 32-bit words in the attached data memory; valid word indices are 0..MEM_WORDS-1.
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- r0_req_i  in  1  requester 0 access request; held until r0_gnt_o.
- r0_we_i  in  1  requester 0 write (1) / read (0).
- r0_addr_i  in  32  requester 0 byte address.
- r0_wdata_i  in  32  requester 0 write data.
- r0_gnt_o  out  1  requester 0 granted this cycle (combinational).
- r0_rvalid_o  out  1  requester 0 completion pulse, one cycle after grant.
- r0_rdata_o  out  32  requester 0 read data, valid with r0_rvalid_o.
- r0_err_o  out  1  requester 0 access error, valid with r0_rvalid_o.
- r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i, r1_gnt_o, r1_rvalid_o, r1_rdata_o, r1_err_o: same as requester 0, for requester 1.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory byte address (memory indexes with bits [31:2]).
- mem_wd_o  out  32  memory write data.
- mem_rd_i  in  32  memory asynchronous read data.

## Operation

- State: last_grant register (1 bit), plus registered response per port (rvalid, rdata, err).
- Arbitration, combinational each cycle:
  - Only one requester active: that requester is granted.
  - Both active: the requester not equal to last_grant is granted.
  - Neither active: no grant.
- last_grant updates to the granted index on any grant and holds otherwise.
- Reset sets last_grant=1, so requester 0 wins the first contention.
- Granted access drives mem_addr_o and mem_wd_o from the winner's inputs.
- mem_we_o = winner's we, provided the access is legal.
- No grant: mem_we_o=0, mem_addr_o=0, mem_wd_o=0.
- Legal access: addr[1:0]==0 and addr[31:2] < MEM_WORDS.
- Illegal access is still granted, but:
  - mem_we_o forced to 0, so memory is untouched.
  - Response carries err=1 and rdata=0.
- Response registered at the grant edge:
  - Read: rdata captures mem_rd_i.
  - Write: rdata=0.
  - rvalid=1 for exactly one cycle; err as computed.
- Non-granted port: rvalid=0. rdata and err hold their previous values.
- Requesters must keep req, we, addr and wdata stable until gnt. They may drop req or present a new request in the cycle after gnt.

## Timing

- Reset values: last_grant=1; r0/r1_rvalid_o=0, rdata=0, err=0. mem_* outputs follow the combinational rule (0 when no request).
- rst_i dominates any simultaneous request. A grant asserted in a cycle where rst_i=1 produces no write and no response. Any pending response is dropped.
- gnt is asserted in cycle N, the same cycle as a qualifying req (zero-latency grant).
- Write commits at the rising edge ending cycle N.
- rvalid/rdata/err are visible in cycle N+1.
- Throughput: one access per cycle in total. Under continuous contention each port gets every second cycle.
- Read after write to the same word in consecutive cycles, any ports, returns the new data.
- Same-cycle conflict on one word: only one access is granted. The loser's access takes effect in a later cycle, in grant order.
- A lone requester is granted every cycle, regardless of last_grant.

## Test plan

- Reset then r0 write 0xDEADBEEF @0x10, next cycle r0 read @0x10 -> gnt same cycle each; r0_rvalid_o pulses in cycles 2 and 3; second response rdata=0xDEADBEEF, err=0.
- Both request continuously for 6 cycles after reset -> grants r0,r1,r0,r1,r0,r1; each rvalid alternates; mem_addr_o follows the winner.
- r1 alone requests 4 back-to-back reads of words 0..3 preloaded 1..4 -> gnt every cycle; r1_rdata_o=1,2,3,4 in cycles N+1..N+4.
- r0 write @0x102 (misaligned), then @0x100 (word 64, out of range with MEM_WORDS=64) -> mem_we_o=0 both cycles; r0_err_o=1 and rdata=0 with each rvalid; memory contents unchanged.
- Both request reads, rst_i asserted in the grant cycle -> no rvalid next cycle. After release, a contention grants r0 first.
- r0 reads @0x20 while r1 writes 0x55 @0x20 in the same cycle, with last_grant=0 -> r1 granted first; r0 granted next cycle and reads 0x55.
